// File: rtl/seq_detector_pkg.sv
// Shared types and helpers for the programmable serial-pattern detector.
package seq_detector_pkg;

    typedef enum logic [1:0] {
        S_FILL  = 2'd0,
        S_HUNT  = 2'd1,
        S_MATCH = 2'd2
    } state_t;

    // Zero-length patterns become length 1; lengths above max_len are cut to max_len.
    function automatic int unsigned clamp_len(input int unsigned len, input int unsigned max_len);
        if (len == 0)
            return 1;
        else if (len > max_len)
            return max_len;
        else
            return len;
    endfunction

endpackage

// File: rtl/seq_match_cnt.sv
// Saturating match counter with a synchronous clear that takes priority over counting.
module seq_match_cnt #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] cnt
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            cnt <= '0;
        else if (clr)
            cnt <= '0;
        else if (inc && (cnt != '1))
            cnt <= cnt + 1'b1;
    end

endmodule

// File: rtl/seq_detector_prog.sv
// Runtime-programmable Moore serial-pattern detector with overlap control and match counter.
module seq_detector_prog
    import seq_detector_pkg::*;
#(
    parameter int                  MAX_LEN         = 8,
    parameter int                  CNT_W           = 8,
    parameter logic [MAX_LEN-1:0]  DEFAULT_PATTERN = 8'b0001_0110,
    parameter int                  DEFAULT_LEN     = 5,
    localparam int                 LW              = $clog2(MAX_LEN + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic               j,
    input  logic               cfg_load,
    input  logic [MAX_LEN-1:0] cfg_pattern,
    input  logic [LW-1:0]      cfg_len,
    input  logic               cfg_overlap,
    input  logic               cnt_clr,
    output logic               w,
    output logic [CNT_W-1:0]   match_cnt
);

    logic [MAX_LEN-1:0] pattern;
    logic [LW-1:0]      len;
    logic               overlap;
    logic [MAX_LEN-1:0] hist;
    logic [LW-1:0]      fill;
    state_t             state;

    logic               sample;
    logic [MAX_LEN-1:0] hist_next;
    logic [MAX_LEN-1:0] mask;
    logic [LW-1:0]      fill_base;
    logic [LW-1:0]      fill_next;
    logic               match;
    state_t             state_next;

    always_comb begin
        sample    = en & ~cfg_load;
        hist_next = (hist << 1) | MAX_LEN'(j);
        mask      = '0;
        for (int unsigned i = 0; i < MAX_LEN; i++)
            mask[i] = (i < 32'(len));
        // A non-overlapping match discards the whole window: only the new bit counts.
        fill_base = (state == S_MATCH && !overlap) ? '0 : fill;
        fill_next = (fill_base < len) ? fill_base + LW'(1) : len;
        match     = (fill_next >= len) && (((hist_next ^ pattern) & mask) == '0);
        if (match)
            state_next = S_MATCH;
        else if (fill_next == len)
            state_next = S_HUNT;
        else
            state_next = S_FILL;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pattern <= DEFAULT_PATTERN;
            len     <= LW'(DEFAULT_LEN);
            overlap <= 1'b1;
            hist    <= '0;
            fill    <= '0;
            state   <= S_FILL;
            w       <= 1'b0;
        end else if (cfg_load) begin
            pattern <= cfg_pattern;
            len     <= LW'(clamp_len(32'(cfg_len), MAX_LEN));
            overlap <= cfg_overlap;
            hist    <= '0;
            fill    <= '0;
            state   <= S_FILL;
            w       <= 1'b0;
        end else if (sample) begin
            hist    <= hist_next;
            fill    <= fill_next;
            state   <= state_next;
            w       <= (state_next == S_MATCH);
        end
    end

    seq_match_cnt #(
        .CNT_W (CNT_W)
    ) u_cnt (
        .clk (clk),
        .rst (rst),
        .clr (cnt_clr),
        .inc (sample & match),
        .cnt (match_cnt)
    );

endmodule

// File: tb/tb_seq_detector_prog.sv
// Randomised and directed bench for seq_detector_prog against a queue-based window model.
module tb_seq_detector_prog;

    localparam int MAX_LEN = 8;
    localparam int LW      = $clog2(MAX_LEN + 1);

    logic               clk = 1'b0;
    logic               rst = 1'b0;
    logic               en = 1'b0;
    logic               j = 1'b0;
    logic               cfg_load = 1'b0;
    logic [MAX_LEN-1:0] cfg_pattern = '0;
    logic [LW-1:0]      cfg_len = '0;
    logic               cfg_overlap = 1'b0;
    logic               cnt_clr = 1'b0;
    logic               w, w2;
    logic [7:0]         match_cnt;
    logic [1:0]         match_cnt2;

    seq_detector_prog #(.MAX_LEN(MAX_LEN), .CNT_W(8)) u_dut (
        .clk(clk), .rst(rst), .en(en), .j(j), .cfg_load(cfg_load),
        .cfg_pattern(cfg_pattern), .cfg_len(cfg_len), .cfg_overlap(cfg_overlap),
        .cnt_clr(cnt_clr), .w(w), .match_cnt(match_cnt)
    );

    seq_detector_prog #(.MAX_LEN(MAX_LEN), .CNT_W(2)) u_dut2 (
        .clk(clk), .rst(rst), .en(en), .j(j), .cfg_load(cfg_load),
        .cfg_pattern(cfg_pattern), .cfg_len(cfg_len), .cfg_overlap(cfg_overlap),
        .cnt_clr(cnt_clr), .w(w2), .match_cnt(match_cnt2)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference: keep the bits received since the last config/reset (or since a
    // consumed non-overlapping match) and compare the newest len bits to the pattern.
    bit         mq[$];
    int         m_len;
    logic [7:0] m_pat;
    bit         m_ovl;
    bit         m_w;
    int         m_cnt, m_cnt2;

    task automatic model_reset();
        mq.delete();
        m_len  = 5;
        m_pat  = 8'b0001_0110;
        m_ovl  = 1'b1;
        m_w    = 1'b0;
        m_cnt  = 0;
        m_cnt2 = 0;
    endtask

    task automatic model_edge();
        bit hit;
        hit = 1'b0;
        if (cfg_load) begin
            m_pat = cfg_pattern;
            m_len = (cfg_len == 0) ? 1 : (int'(cfg_len) > MAX_LEN ? MAX_LEN : int'(cfg_len));
            m_ovl = cfg_overlap;
            mq.delete();
            m_w = 1'b0;
        end else if (en) begin
            mq.push_back(j);
            if (mq.size() > MAX_LEN) void'(mq.pop_front());
            if (mq.size() >= m_len) begin
                hit = 1'b1;
                for (int i = 0; i < m_len; i++)
                    if (mq[mq.size() - 1 - i] != m_pat[i]) hit = 1'b0;
            end
            if (hit && !m_ovl) mq.delete();
            m_w = hit;
        end
        if (cnt_clr) begin
            m_cnt  = 0;
            m_cnt2 = 0;
        end else if (hit) begin
            if (m_cnt < 255) m_cnt++;
            if (m_cnt2 < 3) m_cnt2++;
        end
    endtask

    task automatic drive(input logic e, input logic b, input logic ld, input logic clr);
        en = e; j = b; cfg_load = ld; cnt_clr = clr;
        @(posedge clk);
        model_edge();
        #1;
        check("w", 32'(w), 32'(m_w));
        check("w2", 32'(w2), 32'(m_w));
        check("cnt", 32'(match_cnt), 32'(m_cnt));
        check("cnt2", 32'(match_cnt2), 32'(m_cnt2));
    endtask

    task automatic load(input logic [7:0] pat, input logic [LW-1:0] ln, input logic ovl);
        cfg_pattern = pat; cfg_len = ln; cfg_overlap = ovl;
        drive(1'b1, 1'b1, 1'b1, 1'b0);
    endtask

    task automatic do_reset();
        en = 1'b0; cfg_load = 1'b0; cnt_clr = 1'b0;
        @(posedge clk);
        #2 rst = 1'b0;
        #1;
        check("rst_w", 32'(w), 32'd0);
        check("rst_cnt", 32'(match_cnt), 32'd0);
        model_reset();
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic stream(input logic [15:0] bits, input int n);
        for (int i = n - 1; i >= 0; i--) drive(1'b1, bits[i], 1'b0, 1'b0);
    endtask

    initial begin
        model_reset();
        #12;
        check("init_w", 32'(w), 32'd0);
        check("init_cnt", 32'(match_cnt), 32'd0);
        @(negedge clk);
        rst = 1'b1;

        // Default 10110 overlapping: matches after bits 5 and 8.
        stream(16'b1011_0110, 8);
        check("dflt_cnt", 32'(match_cnt), 32'd2);

        do_reset();
        load(8'b0001_0110, 4'd5, 1'b0);
        stream(16'b1011_0110, 8);
        check("novl_cnt", 32'(match_cnt), 32'd1);

        do_reset();
        load(8'b0000_0111, 4'd3, 1'b1);
        stream(16'b1_1110, 5);
        check("ones_cnt", 32'(match_cnt), 32'd2);
        load(8'b0000_0001, 4'd0, 1'b1);
        drive(1'b1, 1'b1, 1'b0, 1'b0);
        check("len0_w", 32'(w), 32'd1);
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        load(8'h00, 4'd15, 1'b1);
        stream(16'h0000, 9);
        check("len15_w", 32'(w), 32'd1);

        // Enable gating: disabled edges neither consume bits nor change w.
        do_reset();
        stream(16'b101, 3);
        for (int i = 0; i < 3; i++) drive(1'b0, 1'(i), 1'b0, 1'b0);
        stream(16'b10, 2);
        check("en_w", 32'(w), 32'd1);
        for (int i = 0; i < 3; i++) drive(1'b0, 1'(i + 1), 1'b0, 1'b0);
        check("en_hold", 32'(w), 32'd1);

        // Reset mid-stream must not let a match straddle it.
        do_reset();
        stream(16'b1011, 4);
        do_reset();
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        check("rst_nomatch", 32'(w), 32'd0);

        // Saturation and clear priority.
        do_reset();
        load(8'b0000_0111, 4'd3, 1'b1);
        stream(16'h7f, 7);
        check("sat_cnt2", 32'(match_cnt2), 32'd3);
        check("sat_cnt", 32'(match_cnt), 32'd5);
        drive(1'b1, 1'b1, 1'b0, 1'b1);
        check("clr_cnt", 32'(match_cnt), 32'd0);
        check("clr_w", 32'(w), 32'd1);

        // Random stream in default config, then with occasional reconfiguration.
        do_reset();
        for (int i = 0; i < 1000; i++)
            drive($urandom_range(0, 9) != 0, 1'($urandom), 1'b0, $urandom_range(0, 99) == 0);
        for (int i = 0; i < 1500; i++) begin
            cfg_pattern = 8'($urandom);
            cfg_len     = 4'($urandom_range(0, 10));
            cfg_overlap = 1'($urandom);
            drive($urandom_range(0, 9) != 0, 1'($urandom),
                  $urandom_range(0, 79) == 0, $urandom_range(0, 99) == 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/seq_detector_prog.md
Name: seq_detector_prog

Overview:
Parametrised, runtime-programmable Moore serial-pattern detector. It is the generalised successor of the team's fixed 10110 detector. Pattern length (1..MAX_LEN), pattern bits and overlap/non-overlap mode are loaded at runtime. It also provides a sample enable and a saturating match counter. It sits on a 1-bit serial input stream and flags matches to downstream control logic.

Parameters:
MAX_LEN, 8, maximum pattern length in bits (>=2)
CNT_W, 8, match counter width
DEFAULT_PATTERN, 8'b0001_0110, pattern after reset, right-aligned (first-received bit = bit len-1)
DEFAULT_LEN, 5, pattern length after reset

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  asynchronous, active-low reset (0 = reset)
en  in  1  sample enable; j consumed only on edges where en=1
j  in  1  serial data bit
cfg_load  in  1  load cfg_* on this edge
cfg_pattern  in  MAX_LEN  new pattern, right-aligned
cfg_len  in  $clog2(MAX_LEN+1)  new pattern length
cfg_overlap  in  1  1 = overlapping matches allowed
cnt_clr  in  1  synchronous clear of match_cnt
w  out  1  Moore match flag (registered, function of state only)
match_cnt  out  CNT_W  saturating number of matches

Behaviour:
- Reset (rst=0, async): pattern=DEFAULT_PATTERN, len=DEFAULT_LEN, overlap=1, history=0, fill=0, state=S_FILL, w=0, match_cnt=0.
- Registers:
  - hist[MAX_LEN-1:0]: on a sample, hist <= {hist[MAX_LEN-2:0], j}.
  - fill: count of valid history bits, saturates at len.
- Match condition, evaluated on next-state values: fill_next >= len and hist_next[len-1:0] == pattern[len-1:0].
- FSM states and transitions (sample = en=1 and cfg_load=0):
  - S_FILL: fill < len. Sample → S_MATCH if match, S_HUNT if fill_next == len with no match, else stay.
  - S_HUNT: fill == len, last window did not match. Sample → S_MATCH on match, else stay.
  - S_MATCH: w=1. Sample with overlap=1 → S_MATCH/S_HUNT by match, history kept. Sample with overlap=0 → fill cleared to 1 (the new bit), evaluated from S_FILL rules.
  - Non-overlap detail: bits of the matched window are never reused.
- Output and latency:
  - w=1 exactly while state==S_MATCH, i.e. the cycle after the edge that sampled the final pattern bit.
  - No sample (en=0): all state holds, including w.
- Default behaviour: with overlap=1 and the default pattern, the output sequence is bit-identical to the fixed 10110 Moore detector.
- cfg_load: has priority over sampling.
  - Loads pattern, len and overlap.
  - Clears hist, fill and w; state → S_FILL.
  - match_cnt is unchanged.
  - j on that edge is ignored.
- cfg_len clamp: 0 → 1; values > MAX_LEN → MAX_LEN.
- match_cnt:
  - Increments by 1 on each edge that enters or re-enters S_MATCH.
  - Saturates at all-ones; no wrap.
  - cnt_clr wins over a simultaneous increment (result 0).
- Reset mid-stream: partial history is discarded; no match may be formed across a reset.

Decomposition:
- Package seq_detector_pkg holds:
  - state enum {S_FILL, S_HUNT, S_MATCH}, 2 bits.
  - length-clamp function.
- Sub-module seq_match_cnt: saturating counter with clear, width CNT_W.

Test Plan:
- Default config, en=1, j = 1,0,1,1,0,1,1,0 → w=1 in the cycle after bits 5 and 8 only; match_cnt=2.
- cfg_load pattern=10110, len=5, overlap=0; same stream → w=1 only after bit 5; match_cnt=1.
- cfg_load pattern=111, len=3, overlap=1; j = 1,1,1,1,0 → w=1 after bits 3 and 4; match_cnt=2. Then cfg_len=0 loads len=1.
- Default config, j = 1,0,1 then en=0 for 3 edges with j toggling, then en=1 with j = 1,0 → single match after the 5th enabled bit. With en=0 after the match, w stays 1.
- j = 1,0,1,1, then rst low mid-cycle → w=0 and match_cnt=0 immediately. After release, j=0 → no match.
- CNT_W=2, 5 overlapping matches → match_cnt saturates at 3. cnt_clr coincident with a match → 0. A 1000-bit random stream matches a behavioural overlap-detector model.
